// File: rtl/acc_pkg.sv
// Shared types and constants for the product accumulator slice:
// FSM state encoding, default accumulator width and overflow-mode encoding.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int   ACC_WIDTH_DEF = 40;
    localparam logic SAT_WRAP      = 1'b0;
    localparam logic SAT_CLAMP     = 1'b1;

endpackage

// File: rtl/sat_adder.sv
// Combinational signed adder with overflow detection and optional clamp
// to the signed range of ACC_WIDTH.
module sat_adder
    import acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    input  logic                 sat,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    logic [ACC_WIDTH:0] full_s;

    // One extra bit keeps the true sign; overflow when it disagrees with the ACC_WIDTH-bit MSB.
    assign full_s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    assign ovf    = full_s[ACC_WIDTH] ^ full_s[ACC_WIDTH-1];

    // Select clamped limit or wrapped sum.
    always_comb begin
        sum = full_s[ACC_WIDTH-1:0];
        if (ovf && (sat == SAT_CLAMP)) begin
            if (full_s[ACC_WIDTH]) begin
                sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            sum = full_s[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums a group of signed multiplier products terminated by in_last and
// presents the group sum, term count and sticky overflow until accepted.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int   WIDTH     = 16,
    parameter int   ACC_WIDTH = ACC_WIDTH_DEF,
    parameter logic SAT       = SAT_CLAMP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [7:0]           out_count,
    output logic                 out_ovf
);

    localparam int EXT = ACC_WIDTH - 2*WIDTH;

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]           out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH-1:0] sum_s;
    logic                 add_ovf_s;
    logic [7:0]           cnt_inc_s;
    logic                 hs_s;

    assign prod_ext_s = {{EXT{in_data[2*WIDTH-1]}}, in_data};
    assign cnt_inc_s  = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'h01);
    assign in_ready   = (!clear) && (state_q != HOLD);
    assign hs_s       = in_valid && in_ready;

    sat_adder #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_sat_adder (
        .a  (acc_q),
        .b  (prod_ext_s),
        .sat(SAT),
        .sum(sum_s),
        .ovf(add_ovf_s)
    );

    // Next-state and datapath update; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            state_d     = IDLE;
            acc_d       = {ACC_WIDTH{1'b0}};
            cnt_d       = 8'h00;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (hs_s && in_last) begin
                        out_data_d  = sum_s;
                        out_count_d = cnt_inc_s;
                        out_ovf_d   = ovf_q | add_ovf_s;
                        acc_d       = {ACC_WIDTH{1'b0}};
                        cnt_d       = 8'h00;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else if (hs_s) begin
                        acc_d   = sum_s;
                        cnt_d   = cnt_inc_s;
                        ovf_d   = ovf_q | add_ovf_s;
                        state_d = ACCUM;
                    end else begin
                        state_d = state_q;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_WIDTH{1'b0}};
            cnt_q       <= 8'h00;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_WIDTH{1'b0}};
            out_count_q <= 8'h00;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 40-bit saturating instance
// plus two 33-bit instances (saturate / wrap) for the overflow corner.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        v33, l33;
    logic [31:0] d33;
    logic        r33s, r33w, ov33s, ov33w, of33s, of33w;
    logic [32:0] od33s, od33w;
    logic [7:0]  oc33s, oc33w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [39:0] data;
        logic [7:0]  count;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    localparam logic signed [63:0] MAX40 = (64'sd1 <<< 39) - 64'sd1;
    localparam logic signed [63:0] MIN40 = -(64'sd1 <<< 39);

    logic signed [63:0] acc_m = 64'sd0;
    int                 cnt_m = 0;
    logic               ovf_m = 1'b0;

    always #5 clk = ~clk;

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .SAT(1'b1)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .SAT(1'b1)) dut_s33 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(v33), .in_ready(r33s), .in_data(d33), .in_last(l33),
        .out_valid(ov33s), .out_ready(1'b1), .out_data(od33s),
        .out_count(oc33s), .out_ovf(of33s)
    );

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .SAT(1'b0)) dut_w33 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(v33), .in_ready(r33w), .in_data(d33), .in_last(l33),
        .out_valid(ov33w), .out_ready(1'b1), .out_data(od33w),
        .out_count(oc33w), .out_ovf(of33w)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        acc_m = 64'sd0;
        cnt_m = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] d, input logic last);
        logic signed [63:0] s;
        exp_t e;
        s = acc_m + {{32{d[31]}}, d};
        if (s > MAX40) begin
            ovf_m = 1'b1;
            acc_m = MAX40;
        end else if (s < MIN40) begin
            ovf_m = 1'b1;
            acc_m = MIN40;
        end else begin
            acc_m = s;
        end
        if (cnt_m < 255) cnt_m++;
        if (last) begin
            e.data  = acc_m[39:0];
            e.count = cnt_m[7:0];
            e.ovf   = ovf_m;
            sb.push_back(e);
            model_reset();
        end
    endtask

    // Called just after a rising edge; returns just after the handshake edge
    // (or one cycle later for a last term, after the latency check).
    task automatic send(input logic [31:0] d, input logic last);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 40) check_eq("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_step(d, last);
        if (last) begin
            @(negedge clk);
            check_eq("latency_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send33(input logic [31:0] d, input logic last);
        v33 = 1'b1;
        d33 = d;
        l33 = last;
        @(negedge clk);
        check_eq("s33_in_ready", r33s, 1'b1);
        check_eq("w33_in_ready", r33w, 1'b1);
        @(posedge clk); #1;
        v33 = 1'b0;
    endtask

    // Result monitor: compare every accepted result against the scoreboard.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_count", out_count, e.count);
                check_eq("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
        out_ready = 1'b1; v33 = 1'b0; d33 = 32'h0; l33 = 1'b0;
        #12;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 40'h0);
        check_eq("rst_out_count", out_count, 8'h0);
        check_eq("rst_out_ovf", out_ovf, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // 100 - 50 + 7
        send(32'd100, 1'b0);
        send(32'hFFFF_FFCE, 1'b0);
        send(32'd7, 1'b1);

        // single -1
        send(32'hFFFF_FFFF, 1'b1);

        // back-pressure: result held while a product waits
        out_ready = 1'b0;
        send(32'd3, 1'b1);
        in_valid = 1'b1; in_data = 32'd11; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_out_valid", out_valid, 1'b1);
            check_eq("stall_in_ready", in_ready, 1'b0);
            check_eq("stall_out_data", out_data, sb[0].data);
            check_eq("stall_out_count", out_count, sb[0].count);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'd11, 1'b1);

        // clear aborts a partial group
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        clear = 1'b1;
        in_valid = 1'b1; in_data = 32'd1000; in_last = 1'b0;
        @(negedge clk);
        check_eq("clear_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        model_reset();
        send(32'd5, 1'b1);

        // positive and negative saturation with term count pinned at 255
        for (int i = 0; i < 300; i++) send(32'h7FFF_FFFF, (i == 299));
        for (int i = 0; i < 300; i++) send(32'h8000_0000, (i == 299));

        // reset during HOLD
        out_ready = 1'b0;
        send(32'd9, 1'b0);
        send(32'd4, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_rst_out_valid", out_valid, 1'b0);
        check_eq("async_rst_out_data", out_data, 40'h0);
        check_eq("async_rst_out_count", out_count, 8'h0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        send(32'd6, 1'b1);

        // 33-bit overflow corner, saturate vs wrap
        send33(32'h7FFF_FFFF, 1'b0);
        send33(32'h7FFF_FFFF, 1'b0);
        send33(32'h7FFF_FFFF, 1'b1);
        @(negedge clk);
        check_eq("s33_out_valid", ov33s, 1'b1);
        check_eq("s33_out_data", od33s, 33'h0_FFFF_FFFF);
        check_eq("s33_out_ovf", of33s, 1'b1);
        check_eq("s33_out_count", oc33s, 8'd3);
        check_eq("w33_out_valid", ov33w, 1'b1);
        check_eq("w33_out_data", od33w, 33'h1_7FFF_FFFD);
        check_eq("w33_out_ovf", of33w, 1'b1);
        check_eq("w33_out_count", oc33w, 8'd3);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width of the upstream multiplier; products are 2*WIDTH bits signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, accumulator width; legal range ACC_WIDTH >= 2*WIDTH+1.
REQ-003 SHALL have parameter SAT, default 1, where 1 means saturate on overflow and 0 means wrap on overflow.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, synchronous abort of the current group.
REQ-007 SHALL have port in_valid, input, 1, product valid from the multiplier.
REQ-008 SHALL have port in_ready, output, 1, the accumulator can accept a product.
REQ-009 SHALL have port in_data, input, 2*WIDTH, signed product.
REQ-010 SHALL have port in_last, input, 1, the product is the final term of the group.
REQ-011 SHALL have port out_valid, output, 1, group result available.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port out_data, output, ACC_WIDTH, signed group sum.
REQ-014 SHALL have port out_count, output, 8, number of terms in the group.
REQ-015 SHALL have port out_ovf, output, 1, overflow occurred at any point in the group.

Function
REQ-016 SHALL implement states IDLE (no term yet), ACCUM (one or more terms accepted) and HOLD (result presented).
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD or while clear=1.
REQ-018 SHALL define an input handshake as in_valid && in_ready; each handshake adds sign-extended in_data to acc and increments cnt, with cnt saturating at 255.
REQ-019 SHALL take IDLE->ACCUM on a handshake with in_last=0, and remain in ACCUM on further handshakes with in_last=0.
REQ-020 SHALL, on a handshake with in_last=1 from IDLE or ACCUM, load out_data with acc+in_data, out_count with cnt+1 and out_ovf with the group overflow; it SHALL then clear acc, cnt and the overflow flag and enter HOLD.
REQ-021 SHALL assert out_valid exactly in HOLD, with latency of one cycle from the last-term handshake edge.
REQ-022 SHALL hold out_data, out_count and out_ovf stable while out_valid=1 && out_ready=0.
REQ-023 SHALL, on out_valid && out_ready, enter IDLE at the next edge and deassert out_valid; there is no same-cycle bypass.
REQ-024 SHALL detect overflow as a signed overflow of the ACC_WIDTH-bit sum, using the sign of the (ACC_WIDTH+1)-bit true sum.
REQ-025 SHALL, when SAT=1 and overflow occurs, clamp to the signed max/min of ACC_WIDTH and continue accumulating from the clamped value.
REQ-026 SHALL, when SAT=0 and overflow occurs, wrap modulo 2^ACC_WIDTH.
REQ-027 SHALL make the overflow flag sticky within a group under both SAT settings.
REQ-028 SHALL give clear highest priority: it forces IDLE, zeroes acc, cnt and the overflow flag, drops out_valid, and ignores in_valid in the same cycle.
REQ-029 SHALL ignore in_valid and in_data whenever in_ready=0.

Reset
REQ-030 SHALL, on reset=0 and independent of clk, immediately force state IDLE and zero acc, cnt, overflow, out_valid, out_data, out_count and out_ovf.
REQ-031 SHALL present in_ready=1 in the first cycle after reset is released; a reset mid-group or mid-HOLD discards all data.

Structure
REQ-032 SHALL place the state enum typedef, the default ACC_WIDTH and the SAT encoding constants in shared package acc_pkg.
REQ-033 SHALL implement the add/overflow/clamp as combinational sub-module sat_adder (ports a, b, sat, sum, ovf), parameterised by ACC_WIDTH.

Verification
REQ-034 SHALL cover: products 100, -50, 7(last) -> out_data=57, out_count=3, out_ovf=0, out_valid one cycle after the last handshake.
REQ-035 SHALL cover: single product 0xFFFF_FFFF with last -> out_data=0xFF_FFFF_FFFF (-1), out_count=1.
REQ-036 SHALL cover: result with out_ready low for 5 cycles while in_valid=1 -> out_valid and data stable, in_ready=0, no product consumed; out_ready=1 -> IDLE next cycle, the pending product is then accepted.
REQ-037 SHALL cover: ACC_WIDTH=33, SAT=1, three products of 0x7FFF_FFFF (third last) -> out_data=0x0_FFFF_FFFF, out_ovf=1; with SAT=0 -> out_data=0x1_7FFF_FFFD, out_ovf=1.
REQ-038 SHALL cover: two products accepted, clear pulse, then 5(last) -> out_data=5, out_count=1, out_ovf=0.
REQ-039 SHALL cover: reset asserted during HOLD -> out_valid=0 immediately, in_ready=1 after release, and the next group sums from zero.
